// File: rtl/packfloat_round.sv
// -----------------------------------------------------------------------------
// packfloat_round
//   Back end of the fma16 datapath. Takes an unpacked intermediate result
//   (sign, wide signed biased exponent, significand with two integer bits,
//   sticky bit and class flags). Normalizes it one bit per cycle, rounds it
//   and packs it into an IEEE-754 half-precision word with exception flags.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready only in IDLE)
//   in_sign             result sign
//   in_exp              signed biased exponent (<= 62)
//   in_sig              significand, value = sig * 2^(exp-15), binary point
//                       between bits SIGW-3 and SIGW-2
//   in_sticky           OR of bits discarded upstream
//   in_zero/inf/nan     upstream classification (nan > inf > zero)
//   in_invalid          invalid-operation flag, passed through
//   roundmode           00 RZ, 01 RNE, 10 toward -inf, 11 toward +inf
//   out_valid/out_ready output handshake
//   result              packed half-precision value
//   flags               {invalid, overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module packfloat_round #(
  parameter  int SIGW = 22,
  localparam int FLEN = 16,
  localparam int NE   = 5,
  localparam int NF   = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic signed [NE+1:0] in_exp,
  input  logic [SIGW-1:0]      in_sig,
  input  logic                 in_sticky,
  input  logic                 in_zero,
  input  logic                 in_inf,
  input  logic                 in_nan,
  input  logic                 in_invalid,
  input  logic [1:0]           roundmode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLEN-1:0]      result,
  output logic [3:0]           flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RN  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

  // Internal exponent is two bits wider than the input so that the single
  // right shift of an integer-overflowed significand plus a rounding carry
  // cannot wrap when the input exponent is at its maximum.
  localparam int EW = NE + 4;
  localparam int KW = NF + 1;            // kept bits: hidden + fraction
  localparam int GB = SIGW - 3 - NF;     // guard bit index

  localparam logic signed [EW-1:0] EXP_ONE      = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX      = EW'(2**NE - 1);
  localparam logic signed [EW-1:0] EXP_COLLAPSE = EW'(-(NF + 1));

  logic [1:0]             state_reg;
  logic                   sign_reg;
  logic signed [EW-1:0]   exp_reg;
  logic [SIGW-1:0]        sig_reg;
  logic                   sticky_reg;
  logic                   invalid_reg;
  logic [1:0]             rm_reg;
  logic [FLEN-1:0]        result_reg;
  logic [3:0]             flags_reg;

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;

  // ---------------------------------------------------------------------------
  // Special-value encoding for the accept cycle
  // ---------------------------------------------------------------------------
  logic [FLEN-1:0] special_result;

  always_comb begin
    if (in_nan)
      special_result = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};
    else if (in_inf)
      special_result = {in_sign, {NE{1'b1}}, {NF{1'b0}}};
    else
      special_result = {in_sign, {(FLEN-1){1'b0}}};
  end

  // ---------------------------------------------------------------------------
  // One normalization step
  // ---------------------------------------------------------------------------
  logic [SIGW-1:0]      sig_next;
  logic signed [EW-1:0] exp_next;
  logic                 sticky_next;
  logic                 norm_done;

  always_comb begin
    sig_next    = sig_reg;
    exp_next    = exp_reg;
    sticky_next = sticky_reg;
    norm_done   = 1'b0;
    if (exp_reg < EXP_COLLAPSE) begin
      // Far below the subnormal range: everything ends up in sticky at once
      // instead of spending a cycle per bit.
      sticky_next = sticky_reg | (|sig_reg);
      sig_next    = '0;
      exp_next    = EXP_ONE;
    end else if (sig_reg[SIGW-1] || (exp_reg < EXP_ONE)) begin
      sig_next    = sig_reg >> 1;
      exp_next    = exp_reg + EXP_ONE;
      sticky_next = sticky_reg | sig_reg[0];
    end else if ((sig_reg != '0) && !sig_reg[SIGW-2] && (exp_reg > EXP_ONE)) begin
      sig_next = sig_reg << 1;
      exp_next = exp_reg - EXP_ONE;
    end else begin
      norm_done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Rounding and packing of the normalized value
  // ---------------------------------------------------------------------------
  logic [KW-1:0]        kept;
  logic                 guard;
  logic                 st;
  logic                 inexact;
  logic                 inc;
  logic [KW:0]          rounded;
  logic                 hid_after;
  logic signed [EW-1:0] fexp;
  logic [NE-1:0]        efield;
  logic                 ovf;
  logic [FLEN-1:0]      inf_res;
  logic [FLEN-1:0]      max_res;
  logic [FLEN-1:0]      rnd_result;
  logic [3:0]           rnd_flags;

  always_comb begin
    kept    = sig_reg[SIGW-2 -: KW];
    guard   = sig_reg[GB];
    st      = (|sig_reg[GB-1:0]) | sticky_reg;
    inexact = guard | st;
    case (rm_reg)
      RM_RNE:  inc = guard & (st | kept[0]);
      RM_RP:   inc = inexact & ~sign_reg;
      RM_RN:   inc = inexact & sign_reg;
      default: inc = 1'b0;
    endcase
    rounded   = {1'b0, kept} + {{KW{1'b0}}, inc};
    // A carry out of the kept field leaves the fraction at zero and the
    // hidden bit implicitly set one binade higher.
    hid_after = rounded[KW] | rounded[KW-1];
    fexp      = rounded[KW] ? (exp_reg + EXP_ONE) : exp_reg;
    efield    = hid_after ? fexp[NE-1:0] : {NE{1'b0}};
    ovf       = hid_after && (fexp >= EXP_MAX);

    inf_res = {sign_reg, {NE{1'b1}}, {NF{1'b0}}};
    max_res = {sign_reg, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};

    if (ovf) begin
      case (rm_reg)
        RM_RZ:   rnd_result = max_res;
        RM_RP:   rnd_result = sign_reg ? max_res : inf_res;
        RM_RN:   rnd_result = sign_reg ? inf_res : max_res;
        default: rnd_result = inf_res;
      endcase
    end else begin
      rnd_result = {sign_reg, efield, rounded[NF-1:0]};
    end

    rnd_flags = {invalid_reg, ovf, ~kept[KW-1] & inexact, inexact | ovf};
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      sign_reg    <= 1'b0;
      exp_reg     <= '0;
      sig_reg     <= '0;
      sticky_reg  <= 1'b0;
      invalid_reg <= 1'b0;
      rm_reg      <= RM_RZ;
      result_reg  <= '0;
      flags_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            sign_reg    <= in_sign;
            exp_reg     <= EW'(in_exp);
            sig_reg     <= in_sig;
            sticky_reg  <= in_sticky;
            invalid_reg <= in_invalid;
            rm_reg      <= roundmode;
            if (in_nan || in_inf || in_zero) begin
              result_reg <= special_result;
              flags_reg  <= {in_invalid, 3'b000};
              state_reg  <= S_DONE;
            end else begin
              state_reg <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (norm_done) begin
            state_reg <= S_ROUND;
          end else begin
            sig_reg    <= sig_next;
            exp_reg    <= exp_next;
            sticky_reg <= sticky_next;
          end
        end
        S_ROUND: begin
          result_reg <= rnd_result;
          flags_reg  <= rnd_flags;
          state_reg  <= S_DONE;
        end
        default: begin
          if (out_ready)
            state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packfloat_round.sv
// -----------------------------------------------------------------------------
// tb_packfloat_round
//   Directed-vector bench for packfloat_round. Each scenario task drives its
//   operations and compares result, flags and latency against hand-computed
//   values. One line is printed per transaction.
// -----------------------------------------------------------------------------
module tb_packfloat_round;

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RN  = 2'b10;
  localparam logic [1:0] RP  = 2'b11;

  // class argument bit order: {nan, inf, zero, invalid}
  localparam logic [3:0] C_NONE = 4'b0000;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic signed [6:0] in_exp;
  logic [21:0] in_sig;
  logic        in_sticky;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        in_invalid;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks;
  int errors;

  packfloat_round dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_sig     (in_sig),
    .in_sticky  (in_sticky),
    .in_zero    (in_zero),
    .in_inf     (in_inf),
    .in_nan     (in_nan),
    .in_invalid (in_invalid),
    .roundmode  (roundmode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, count edges from the accepting edge to out_valid
  // (0 when the bound expires), capture the output and drain it.
  task automatic run_op(input logic s, input int e, input logic [21:0] sg,
                        input logic stk, input logic [1:0] rm, input logic [3:0] cls,
                        output logic [15:0] res, output logic [3:0] fl, output int n);
    @(negedge clk);
    in_sign    = s;
    in_exp     = e[6:0];
    in_sig     = sg;
    in_sticky  = stk;
    roundmode  = rm;
    in_nan     = cls[3];
    in_inf     = cls[2];
    in_zero    = cls[1];
    in_invalid = cls[0];
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) n = 0;
    res = result;
    fl  = flags;
    $display("op s=%0d e=%0d sig=%h stk=%0d rm=%0d cls=%b -> result=%h flags=%b edges=%0d",
             s, e, sg, stk, rm, cls, res, fl, n);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #23;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h flags=%b, expected 1 0 0000 0000",
               in_ready, out_valid, result, flags);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_normalize;
    logic [15:0] r; logic [3:0] f; int n;
    run_op(1'b0, 15, 22'h1 << 20, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C00 || f !== 4'b0000 || n !== 3) begin
      errors++;
      $display("FAIL one: result=%h flags=%b edges=%0d, expected 3c00 0000 3", r, f, n);
    end
    run_op(1'b0, 15, 22'h1 << 21, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h4000 || f !== 4'b0000 || n !== 4) begin
      errors++;
      $display("FAIL carry_norm: result=%h flags=%b edges=%0d, expected 4000 0000 4", r, f, n);
    end
    run_op(1'b0, 16, 22'h1 << 19, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C00 || f !== 4'b0000 || n !== 4) begin
      errors++;
      $display("FAIL left_shift: result=%h flags=%b edges=%0d, expected 3c00 0000 4", r, f, n);
    end
  endtask

  task automatic test_rounding;
    logic [15:0] r; logic [3:0] f; int n;
    logic [21:0] tie_even;
    logic [21:0] tie_odd;
    logic [21:0] all_ones;
    tie_even = (22'h1 << 20) | (22'h1 << 9);
    tie_odd  = (22'h1 << 20) | (22'h1 << 10) | (22'h1 << 9);
    all_ones = 22'h1FFE00;
    run_op(1'b0, 15, tie_even, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C00 || f !== 4'b0001) begin
      errors++;
      $display("FAIL tie_rne_even: result=%h flags=%b, expected 3c00 0001", r, f);
    end
    run_op(1'b0, 15, tie_even, 1'b0, RP, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C01 || f !== 4'b0001) begin
      errors++;
      $display("FAIL tie_rp: result=%h flags=%b, expected 3c01 0001", r, f);
    end
    run_op(1'b0, 15, tie_even, 1'b0, RZ, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C00 || f !== 4'b0001) begin
      errors++;
      $display("FAIL tie_rz: result=%h flags=%b, expected 3c00 0001", r, f);
    end
    run_op(1'b1, 15, tie_even, 1'b0, RN, C_NONE, r, f, n);
    checks++;
    if (r !== 16'hBC01 || f !== 4'b0001) begin
      errors++;
      $display("FAIL tie_rn_neg: result=%h flags=%b, expected bc01 0001", r, f);
    end
    run_op(1'b0, 15, tie_odd, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C02 || f !== 4'b0001) begin
      errors++;
      $display("FAIL tie_rne_odd: result=%h flags=%b, expected 3c02 0001", r, f);
    end
    run_op(1'b0, 15, 22'h1 << 20, 1'b1, RP, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h3C01 || f !== 4'b0001) begin
      errors++;
      $display("FAIL sticky_rp: result=%h flags=%b, expected 3c01 0001", r, f);
    end
    run_op(1'b0, 15, all_ones, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h4000 || f !== 4'b0001 || n !== 3) begin
      errors++;
      $display("FAIL round_carry: result=%h flags=%b edges=%0d, expected 4000 0001 3", r, f, n);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] r; logic [3:0] f; int n;
    run_op(1'b0, 31, 22'h1 << 20, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h7C00 || f !== 4'b0101 || n !== 3) begin
      errors++;
      $display("FAIL ovf_rne: result=%h flags=%b edges=%0d, expected 7c00 0101 3", r, f, n);
    end
    run_op(1'b0, 31, 22'h1 << 20, 1'b0, RZ, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h7BFF || f !== 4'b0101) begin
      errors++;
      $display("FAIL ovf_rz: result=%h flags=%b, expected 7bff 0101", r, f);
    end
    run_op(1'b1, 31, 22'h1 << 20, 1'b0, RP, C_NONE, r, f, n);
    checks++;
    if (r !== 16'hFBFF || f !== 4'b0101) begin
      errors++;
      $display("FAIL ovf_rp_neg: result=%h flags=%b, expected fbff 0101", r, f);
    end
    run_op(1'b0, 31, 22'h1 << 20, 1'b0, RN, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h7BFF || f !== 4'b0101) begin
      errors++;
      $display("FAIL ovf_rn_pos: result=%h flags=%b, expected 7bff 0101", r, f);
    end
    run_op(1'b1, 31, 22'h1 << 20, 1'b0, RN, C_NONE, r, f, n);
    checks++;
    if (r !== 16'hFC00 || f !== 4'b0101) begin
      errors++;
      $display("FAIL ovf_rn_neg: result=%h flags=%b, expected fc00 0101", r, f);
    end
  endtask

  task automatic test_subnormal;
    logic [15:0] r; logic [3:0] f; int n;
    run_op(1'b0, 0, 22'h1 << 20, 1'b0, RNE, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h0200 || f !== 4'b0000 || n !== 4) begin
      errors++;
      $display("FAIL subnorm_exact: result=%h flags=%b edges=%0d, expected 0200 0000 4", r, f, n);
    end
    run_op(1'b0, -20, 22'h1 << 20, 1'b0, RZ, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h0000 || f !== 4'b0011 || n !== 4) begin
      errors++;
      $display("FAIL collapse_rz: result=%h flags=%b edges=%0d, expected 0000 0011 4", r, f, n);
    end
    run_op(1'b0, -20, 22'h1 << 20, 1'b0, RP, C_NONE, r, f, n);
    checks++;
    if (r !== 16'h0001 || f !== 4'b0011) begin
      errors++;
      $display("FAIL collapse_rp: result=%h flags=%b, expected 0001 0011", r, f);
    end
  endtask

  task automatic test_specials;
    logic [15:0] r; logic [3:0] f; int n;
    run_op(1'b1, 15, 22'h1 << 20, 1'b0, RNE, 4'b1001, r, f, n);
    checks++;
    if (r !== 16'h7E00 || f !== 4'b1000 || n !== 1) begin
      errors++;
      $display("FAIL nan_invalid: result=%h flags=%b edges=%0d, expected 7e00 1000 1", r, f, n);
    end
    run_op(1'b1, 15, 22'h1 << 20, 1'b0, RNE, 4'b0100, r, f, n);
    checks++;
    if (r !== 16'hFC00 || f !== 4'b0000 || n !== 1) begin
      errors++;
      $display("FAIL inf_neg: result=%h flags=%b edges=%0d, expected fc00 0000 1", r, f, n);
    end
    run_op(1'b1, 15, 22'h1 << 20, 1'b0, RNE, 4'b0010, r, f, n);
    checks++;
    if (r !== 16'h8000 || f !== 4'b0000 || n !== 1) begin
      errors++;
      $display("FAIL zero_neg: result=%h flags=%b edges=%0d, expected 8000 0000 1", r, f, n);
    end
    run_op(1'b0, 15, 22'h1 << 20, 1'b0, RNE, 4'b1110, r, f, n);
    checks++;
    if (r !== 16'h7E00 || f !== 4'b0000) begin
      errors++;
      $display("FAIL nan_priority: result=%h flags=%b, expected 7e00 0000", r, f);
    end
  endtask

  task automatic test_back_to_back;
    int  n;
    logic seen;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 7'sd15; in_sig = 22'h1 << 20; in_sticky = 1'b0;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; in_invalid = 1'b0;
    roundmode = RNE; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_timeout: out_valid=%b after %0d edges, expected 1", out_valid, n);
    end
    // A second request that must be ignored while the result is pending.
    in_exp = 7'sd16; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result !== 16'h3C00 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: result=%h out_valid=%b in_ready=%b, expected 3c00 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    $display("hold op drained: out_valid=%b in_ready=%b", out_valid, in_ready);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_drain: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL hold_ignored: out_valid seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 7'sd16; in_sig = 22'h1; in_sticky = 1'b0;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; in_invalid = 1'b0;
    roundmode = RNE; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    $display("reset mid-op: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b result=%h, expected 0 1 0000",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse: out_valid seen=%b, expected 0", seen);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_sign    = 1'b0;
    in_exp     = '0;
    in_sig     = '0;
    in_sticky  = 1'b0;
    in_zero    = 1'b0;
    in_inf     = 1'b0;
    in_nan     = 1'b0;
    in_invalid = 1'b0;
    roundmode  = RNE;
    reset_n    = 1'b1;
    #2;
    test_reset;
    test_normalize;
    test_rounding;
    test_overflow;
    test_subnormal;
    test_specials;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
